// File: rtl/ffsr_bank.sv
// Bank of WIDTH clocked SR flip-flops with shared synchronous clear and enable,
// edge pulses, a sticky collision flag and a saturating change counter.
module ffsr_bank #(
  parameter int              WIDTH = 4,
  parameter int              MODE  = 0,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter int              CNT_W = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic             collision,
  output logic [CNT_W-1:0] change_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_nxt;
  logic             sr_both;

  // S=R=1 resolution is fixed by MODE at elaboration time.
  always_comb begin
    q_nxt = q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] && r[i]) begin
          if (MODE == 1)      q_nxt[i] = 1'b1;
          else if (MODE == 2) q_nxt[i] = 1'b0;
          else if (MODE == 3) q_nxt[i] = ~q[i];
          else                q_nxt[i] = q[i];
        end else if (s[i]) begin
          q_nxt[i] = 1'b1;
        end else if (r[i]) begin
          q_nxt[i] = 1'b0;
        end
      end
    end
  end

  assign sr_both = en && (|(s & r));

  always_ff @(posedge clock) begin
    if (clear) begin
      q            <= INIT;
      q_rise       <= '0;
      q_fall       <= '0;
      collision    <= 1'b0;
      change_count <= '0;
    end else begin
      q      <= q_nxt;
      q_rise <= q_nxt & ~q;
      q_fall <= ~q_nxt & q;
      if (sr_both) collision <= 1'b1;
      if ((q_nxt != q) && (change_count != CNT_MAX))
        change_count <= change_count + CNT_ONE;
    end
  end

endmodule

// File: doc/ffsr_bank.md
Name: ffsr_bank

Overview:
- Parametrised successor to the single-bit clocked SR flip-flop: a WIDTH-channel bank of clocked SR flip-flops sharing one clock and one synchronous clear.
- Adds a selectable S&R collision mode, a clock enable, a programmable reset value, per-channel edge pulses, a sticky collision flag and a saturating change counter.
- Used for latched status/flag registers, for example in the VGA controller (sync/blank/error flags).

Parameters:
- WIDTH, 4, number of independent SR channels (>=1).
- MODE, 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle (JK behaviour).
- INIT, 0, WIDTH-bit value loaded into q by clear.
- CNT_W, 8, width of change_count (>=1).

Ports:
- clock  input  1  system clock, all state updates on the rising edge.
- clear  input  1  synchronous, active-high reset; highest priority.
- en  input  1  clock enable for the flip-flops; when 0, q holds.
- s  input  WIDTH  per-channel set request.
- r  input  WIDTH  per-channel reset request.
- q  output  WIDTH  registered flip-flop state.
- q_rise  output  WIDTH  one-cycle pulse per bit that went 0->1 on this edge.
- q_fall  output  WIDTH  one-cycle pulse per bit that went 1->0 on this edge.
- collision  output  1  sticky flag: set when any channel saw s=r=1 with en=1.
- change_count  output  CNT_W  number of edges on which q changed (any bit); saturates.

Behaviour:
- All outputs are registered. Nothing updates except on the rising edge of clock.
- Reset (clear=1 at an edge), which overrides en, s and r:
  - q <= INIT.
  - q_rise <= 0, q_fall <= 0.
  - collision <= 0.
  - change_count <= 0.
- Reset mid-operation discards any pending or simultaneous s/r requests on that edge.
- Per channel i, when clear=0 and en=1, next state:
  - s=0, r=0: hold.
  - s=1, r=0: 1.
  - s=0, r=1: 0.
  - s=1, r=1: MODE 0 hold; MODE 1 -> 1; MODE 2 -> 0; MODE 3 -> ~q[i].
- When clear=0 and en=0:
  - q holds regardless of s and r.
  - No collision is recorded.
- Latency:
  - q reflects s/r one edge after they are sampled (1 cycle).
  - q_rise and q_fall are asserted in the same cycle as the new q value.
- Edge pulses:
  - q_rise[i] = 1 for exactly one cycle when the edge changes q[i] from 0 to 1; q_fall[i] likewise for 1 to 0.
  - Otherwise both are 0, including on hold and on re-setting an already-set bit.
- collision:
  - Set on the edge where any bit has s[i]&r[i] with en=1 and clear=0.
  - Stays 1 until clear, in every MODE.
- change_count:
  - Increments by 1 on each edge where the next q differs from the current q (any number of bits changing counts once).
  - Saturates at 2^CNT_W-1, no wrap.
  - A change caused by clear is not counted (the counter resets).
- Channels are fully independent. Mixed set, reset and hold across bits on the same edge is legal.
- Illegal parameter values (WIDTH<1, MODE>3, CNT_W<1) are not supported.

Test Plan (WIDTH=4, INIT=4'b0000, CNT_W=3 unless noted; clock period 50):
- Reset:
  - Stimulus: clear=1 for 2 edges with s=4'b1111.
  - Required: q=0000, q_rise=q_fall=0000, collision=0, change_count=0.
  - Repeat with INIT=4'b1010: q=1010 after clear.
- Set/reset/hold:
  - Stimulus: en=1; s=0011,r=0 for 1 edge; then s=0,r=0001; then s=r=0 for 2 edges.
  - Required q sequence: 0011, 0010, 0010, 0010.
  - Required pulses: q_rise=0011 then 0000; q_fall=0001 on the second edge.
  - Required: change_count=2.
- Collision modes:
  - Stimulus: from q=0000, set s=r=0001 for 2 edges.
  - Required: MODE0 -> q stays 0000; MODE1 -> 0001; MODE2 -> 0000; MODE3 -> 0001 then 0000.
  - Required in every MODE: collision=1 after the first edge and held until clear.
- Enable gating:
  - Stimulus: en=0, s=1111, r=0 for 3 edges, then s=r=1111 for 1 edge.
  - Required: q unchanged, pulses 0, change_count unchanged, collision stays 0.
- Counter saturation:
  - Stimulus: MODE3, en=1, s=r=0001 for 10 edges.
  - Required: q[0] toggles every edge; change_count reaches 7 after 7 edges and stays at 7.
- Clear mid-operation:
  - Stimulus: q=0110 with count 3; clear=1 on the same edge as s=1001.
  - Required: q=0000, counter=0, collision=0, no q_rise pulse.
